// File: rtl/rank_pipe_rr.sv
// rank_pipe_rr: buffers requests in order to the rank engine named by their op code,
// and collects engine results round-robin into an output FIFO.
module rank_pipe_rr #(
  parameter int NUM_RANK_OPS      = 4,
  parameter int RANK_CODE_BITS    = 2,
  parameter int META_WIDTH        = 16,
  parameter int FLOW_ID_WIDTH     = 16,
  parameter int FLOW_WEIGHT_WIDTH = 8,
  parameter int RANK_WIDTH        = 16,
  parameter int L2_IN_DEPTH       = 4,
  parameter int L2_OUT_DEPTH      = 4,
  parameter int DEFAULT_OP        = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  output logic                                     busy,
  input  logic                                     insert,
  input  logic [META_WIDTH-1:0]                    meta_in,
  input  logic [RANK_CODE_BITS-1:0]                rank_op_in,
  input  logic [FLOW_ID_WIDTH-1:0]                 flowID_in,
  input  logic [FLOW_WEIGHT_WIDTH-1:0]             flow_weight_in,
  output logic [NUM_RANK_OPS-1:0]                  eng_insert,
  output logic [NUM_RANK_OPS*META_WIDTH-1:0]       eng_meta_in,
  output logic [NUM_RANK_OPS*FLOW_ID_WIDTH-1:0]    eng_flowID_in,
  output logic [NUM_RANK_OPS*FLOW_WEIGHT_WIDTH-1:0] eng_weight_in,
  input  logic [NUM_RANK_OPS-1:0]                  eng_busy,
  input  logic [NUM_RANK_OPS-1:0]                  eng_valid_out,
  input  logic [NUM_RANK_OPS*RANK_WIDTH-1:0]       eng_rank_out,
  input  logic [NUM_RANK_OPS*META_WIDTH-1:0]       eng_meta_out,
  output logic [NUM_RANK_OPS-1:0]                  eng_remove,
  input  logic                                     remove,
  output logic                                     valid_out,
  output logic [RANK_WIDTH-1:0]                    rank_out,
  output logic [META_WIDTH-1:0]                    meta_out,
  output logic [15:0]                              bad_op_count,
  output logic [15:0]                              drop_count
);
  localparam int CB = RANK_CODE_BITS;
  localparam int IW = CB + META_WIDTH + FLOW_ID_WIDTH + FLOW_WEIGHT_WIDTH;
  localparam int OW = RANK_WIDTH + META_WIDTH;
  localparam logic [CB:0] NOPS = (CB+1)'(NUM_RANK_OPS);
  localparam logic [CB-1:0] DEF_OP = CB'(DEFAULT_OP);
  localparam logic [L2_IN_DEPTH:0] IN_HI = (L2_IN_DEPTH+1)'((1 << L2_IN_DEPTH) - 1);
  localparam logic [L2_OUT_DEPTH:0] OUT_HI = (L2_OUT_DEPTH+1)'((1 << L2_OUT_DEPTH) - 1);
  logic [IW-1:0] in_mem [1 << L2_IN_DEPTH];
  logic [OW-1:0] out_mem [1 << L2_OUT_DEPTH];
  logic [L2_IN_DEPTH-1:0] in_wp, in_rp;
  logic [L2_IN_DEPTH:0] in_cnt;
  logic [L2_OUT_DEPTH-1:0] out_wp, out_rp;
  logic [L2_OUT_DEPTH:0] out_cnt;
  logic [CB-1:0] head_op, gnt, ptr;
  logic [META_WIDTH-1:0] head_meta;
  logic [FLOW_ID_WIDTH-1:0] head_flow;
  logic [FLOW_WEIGHT_WIDTH-1:0] head_w;
  logic [(1 << CB)-1:0] busy_x, vld_x;
  logic [OW-1:0] out_din;
  logic bad_op, in_wr, in_rd, out_wr, out_rd, any;
  assign busy = in_cnt >= IN_HI;
  assign in_wr = insert && !busy;
  assign bad_op = {1'b0, rank_op_in} >= NOPS;
  assign {head_op, head_meta, head_flow, head_w} = in_mem[in_rp];
  assign busy_x = (1 << CB)'(eng_busy);
  assign vld_x = (1 << CB)'(eng_valid_out);
  // head-of-line blocking: only the head may dispatch, and only to its own engine
  assign in_rd = in_cnt != 0 && !busy_x[head_op];
  assign valid_out = out_cnt != 0;
  assign out_rd = remove && valid_out;
  // a pop in the same cycle frees the slot, so a write at the threshold stays legal
  assign out_wr = rst && any && (out_cnt < OUT_HI || out_rd);
  assign {rank_out, meta_out} = valid_out ? out_mem[out_rp] : '0;
  for (genvar i = 0; i < NUM_RANK_OPS; i++) begin : g_eng
    assign eng_insert[i] = in_rd && head_op == CB'(i);
    assign eng_meta_in[i*META_WIDTH +: META_WIDTH] = eng_insert[i] ? head_meta : '0;
    assign eng_flowID_in[i*FLOW_ID_WIDTH +: FLOW_ID_WIDTH] = eng_insert[i] ? head_flow : '0;
    assign eng_weight_in[i*FLOW_WEIGHT_WIDTH +: FLOW_WEIGHT_WIDTH] = eng_insert[i] ? head_w : '0;
    assign eng_remove[i] = out_wr && gnt == CB'(i);
  end
  // scan downward from the farthest offset so the engine nearest the pointer wins
  always_comb begin
    logic [CB:0] s;
    s = '0;
    gnt = ptr;
    any = 1'b0;
    for (int k = NUM_RANK_OPS - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (CB+1)'(k);
      s = s >= NOPS ? s - NOPS : s;
      if (vld_x[s[CB-1:0]]) begin
        any = 1'b1;
        gnt = s[CB-1:0];
      end
    end
  end
  always_comb begin
    out_din = '0;
    for (int i = 0; i < NUM_RANK_OPS; i++)
      if (eng_remove[i]) out_din = {eng_rank_out[i*RANK_WIDTH +: RANK_WIDTH], eng_meta_out[i*META_WIDTH +: META_WIDTH]};
  end
  always_ff @(posedge clk) begin
    if (in_wr) in_mem[in_wp] <= {bad_op ? DEF_OP : rank_op_in, meta_in, flowID_in, flow_weight_in};
    if (out_wr) out_mem[out_wp] <= out_din;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wp <= '0;
      in_rp <= '0;
      in_cnt <= '0;
      out_wp <= '0;
      out_rp <= '0;
      out_cnt <= '0;
      ptr <= '0;
      bad_op_count <= '0;
      drop_count <= '0;
    end else begin
      if (in_wr) in_wp <= in_wp + 1;
      if (in_rd) in_rp <= in_rp + 1;
      in_cnt <= in_cnt + (L2_IN_DEPTH+1)'(in_wr) - (L2_IN_DEPTH+1)'(in_rd);
      if (out_wr) out_wp <= out_wp + 1;
      if (out_rd) out_rp <= out_rp + 1;
      out_cnt <= out_cnt + (L2_OUT_DEPTH+1)'(out_wr) - (L2_OUT_DEPTH+1)'(out_rd);
      if (out_wr) ptr <= ({1'b0, gnt} + (CB+1)'(1) == NOPS) ? '0 : gnt + CB'(1);
      if (in_wr && bad_op && bad_op_count != 16'hFFFF) bad_op_count <= bad_op_count + 1;
      if (insert && busy && drop_count != 16'hFFFF) drop_count <= drop_count + 1;
    end
  end
endmodule

// File: tb/tb_rank_pipe_rr.sv
// tb_rank_pipe_rr: scoreboard bench for rank_pipe_rr with 4 engines and 3-bit op codes,
// so codes 4..7 exercise the out-of-range path.
module tb_rank_pipe_rr;
  localparam int N = 4;
  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] meta;
    logic [15:0] flow;
    logic [7:0]  w;
  } ent_t;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic busy, insert, remove, valid_out;
  logic [15:0] meta_in, flowID_in, rank_out, meta_out, bad_op_count, drop_count;
  logic [2:0] rank_op_in;
  logic [7:0] flow_weight_in;
  logic [N-1:0] eng_insert, eng_busy, eng_valid_out, eng_remove;
  logic [N*16-1:0] eng_meta_in, eng_flowID_in, eng_rank_out, eng_meta_out;
  logic [N*8-1:0] eng_weight_in;
  logic [15:0] er [N];
  logic [15:0] em [N];
  assign eng_rank_out = {er[3], er[2], er[1], er[0]};
  assign eng_meta_out = {em[3], em[2], em[1], em[0]};
  rank_pipe_rr #(.NUM_RANK_OPS(N), .RANK_CODE_BITS(3), .DEFAULT_OP(0)) dut (
    .clk(clk), .rst(rst), .busy(busy), .insert(insert), .meta_in(meta_in),
    .rank_op_in(rank_op_in), .flowID_in(flowID_in), .flow_weight_in(flow_weight_in),
    .eng_insert(eng_insert), .eng_meta_in(eng_meta_in), .eng_flowID_in(eng_flowID_in),
    .eng_weight_in(eng_weight_in), .eng_busy(eng_busy), .eng_valid_out(eng_valid_out),
    .eng_rank_out(eng_rank_out), .eng_meta_out(eng_meta_out), .eng_remove(eng_remove),
    .remove(remove), .valid_out(valid_out), .rank_out(rank_out), .meta_out(meta_out),
    .bad_op_count(bad_op_count), .drop_count(drop_count)
  );
  int checks = 0, failures = 0;
  ent_t disp_q [$];
  logic [31:0] out_q [$];
  int occ = 0, ptr = 0, bad_m = 0, drop_m = 0, m_g;
  logic [N-1:0] m_ins, m_rm;
  ent_t m_e;
  logic [31:0] m_o;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // one clock of stimulus; entries enter the model once the DUT has had the edge to take them
  task automatic step(input logic ins, input logic [2:0] op, input logic [15:0] m, input logic [15:0] f, input logic [7:0] w);
    logic acc;
    ent_t e;
    acc = disp_q.size() < 15;
    check("busy", busy, !acc);
    for (int i = 0; i < N; i++) begin
      er[i] = 16'($urandom);
      em[i] = 16'($urandom);
    end
    insert = ins;
    rank_op_in = op;
    meta_in = m;
    flowID_in = f;
    flow_weight_in = w;
    @(posedge clk);
    #1;
    insert = 1'b0;
    if (ins && acc) begin
      e.op = op >= 3'd4 ? 2'd0 : op[1:0];
      e.meta = m;
      e.flow = f;
      e.w = w;
      disp_q.push_back(e);
      if (op >= 3'd4) bad_m++;
    end
    if (ins && !acc) drop_m++;
    check("bad_op_count", bad_op_count, 64'(bad_m));
    check("drop_count", drop_count, 64'(drop_m));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 16'd0, 16'd0, 8'd0);
  endtask
  always @(negedge clk) if (rst) begin
    m_ins = '0;
    if (disp_q.size() > 0 && !eng_busy[disp_q[0].op]) m_ins[disp_q[0].op] = 1'b1;
    check("eng_insert", eng_insert, m_ins);
    if (m_ins != 0) begin
      m_e = disp_q.pop_front();
      check("eng_meta_in", eng_meta_in, 64'(m_e.meta) << (16 * m_e.op));
      check("eng_flowID_in", eng_flowID_in, 64'(m_e.flow) << (16 * m_e.op));
      check("eng_weight_in", eng_weight_in, 64'(m_e.w) << (8 * m_e.op));
    end
    m_rm = '0;
    m_g = 0;
    if (occ < 15 || (remove && occ > 0))
      for (int k = N - 1; k >= 0; k--)
        if (eng_valid_out[(ptr + k) % N]) begin
          m_g = (ptr + k) % N;
          m_rm = '0;
          m_rm[m_g] = 1'b1;
        end
    check("eng_remove", eng_remove, m_rm);
    check("valid_out", valid_out, occ != 0);
    if (remove && occ > 0) begin
      m_o = out_q.pop_front();
      check("rank_out", rank_out, m_o[31:16]);
      check("meta_out", meta_out, m_o[15:0]);
      occ--;
    end
    if (m_rm != 0) begin
      out_q.push_back({er[m_g], em[m_g]});
      occ++;
      ptr = (m_g + 1) % N;
    end
  end
  initial begin
    insert = 1'b1;
    remove = 1'b1;
    rank_op_in = 3'd0;
    meta_in = 16'd0;
    flowID_in = 16'd0;
    flow_weight_in = 8'd0;
    eng_busy = '0;
    eng_valid_out = '1;
    for (int i = 0; i < N; i++) begin
      er[i] = 16'(i + 1);
      em[i] = 16'(i + 16);
    end
    #12;
    check("rst_busy", busy, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_eng_insert", eng_insert, 0);
    check("rst_eng_remove", eng_remove, 0);
    check("rst_rank_out", rank_out, 0);
    check("rst_meta_out", meta_out, 0);
    check("rst_bad_op_count", bad_op_count, 0);
    check("rst_drop_count", drop_count, 0);
    insert = 1'b0;
    remove = 1'b0;
    eng_valid_out = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    step(1'b1, 3'd1, 16'hA5A5, 16'd3, 8'd7);
    check("lat_eng_insert", eng_insert, 4'b0010);
    check("lat_meta", eng_meta_in[31:16], 16'hA5A5);
    check("lat_flow", eng_flowID_in[31:16], 16'd3);
    idle(2);
    step(1'b1, 3'd5, 16'h1234, 16'd9, 8'd2);
    check("bad_op_engine", eng_insert, 4'b0001);
    check("bad_op_meta", eng_meta_in[15:0], 16'h1234);
    check("bad_op_count_one", bad_op_count, 1);
    idle(2);
    eng_busy = 4'b0001;
    for (int i = 0; i < 16; i++) step(1'b1, 3'd0, 16'(16'h100 + i), 16'(i), 8'(i));
    check("fill_busy", busy, 1);
    check("fill_drop", drop_count, 1);
    eng_busy = '0;
    idle(20);
    check("fill_drained", disp_q.size(), 0);
    remove = 1'b1;
    eng_valid_out = '1;
    idle(8);
    eng_valid_out = '0;
    idle(10);
    remove = 1'b0;
    eng_valid_out = 4'b0001;
    idle(20);
    check("out_full_hold", eng_remove, 0);
    remove = 1'b1;
    #1 check("out_full_wr", eng_remove, 4'b0001);
    idle(1);
    eng_valid_out = '0;
    idle(20);
    for (int i = 0; i < 200; i++) begin
      eng_busy = 4'($urandom) & 4'($urandom);
      eng_valid_out = 4'($urandom);
      remove = 1'($urandom);
      step(1'($urandom), 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 8'($urandom));
    end
    eng_busy = '1;
    remove = 1'b0;
    eng_valid_out = 4'b0001;
    for (int i = 0; i < 5; i++) step(1'b1, 3'(i), 16'(16'hBEE0 + i), 16'(i), 8'(i));
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid_out", valid_out, 0);
    check("mid_rst_eng_insert", eng_insert, 0);
    check("mid_rst_eng_remove", eng_remove, 0);
    check("mid_rst_counts", {bad_op_count, drop_count}, 0);
    disp_q.delete();
    out_q.delete();
    occ = 0;
    ptr = 0;
    bad_m = 0;
    drop_m = 0;
    eng_busy = '0;
    eng_valid_out = '0;
    remove = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    idle(10);
    check("post_rst_valid_out", valid_out, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rank_pipe_rr.md
RANK_PIPE_RR -- requirements
Module: rank_pipe_rr

Interface
REQ-001 SHALL have parameter NUM_RANK_OPS, default 4: number of attached rank engines, range 1..2^RANK_CODE_BITS.
REQ-002 SHALL have parameter RANK_CODE_BITS, default 2: width of the rank-op code.
REQ-003 SHALL have parameters META_WIDTH 16, FLOW_ID_WIDTH 16, FLOW_WEIGHT_WIDTH 8, RANK_WIDTH 16: field widths.
REQ-004 SHALL have parameters L2_IN_DEPTH 4 and L2_OUT_DEPTH 4: log2 of input and output FIFO depths.
REQ-005 SHALL have parameter DEFAULT_OP, default 0: engine index used for out-of-range op codes.
REQ-006 SHALL use one clock; reset is asynchronous and active-low. Ports: clk in 1 (clock); rst in 1 (asynchronous, active-low reset).
REQ-007 Upstream ports: busy out 1; insert in 1; meta_in in META_WIDTH; rank_op_in in RANK_CODE_BITS; flowID_in in FLOW_ID_WIDTH; flow_weight_in in FLOW_WEIGHT_WIDTH.
REQ-008 Engine request ports, one slice per engine i: eng_insert out NUM_RANK_OPS; eng_meta_in out NUM_RANK_OPS*META_WIDTH; eng_flowID_in out NUM_RANK_OPS*FLOW_ID_WIDTH; eng_weight_in out NUM_RANK_OPS*FLOW_WEIGHT_WIDTH; eng_busy in NUM_RANK_OPS.
REQ-009 Engine result ports: eng_valid_out in NUM_RANK_OPS; eng_rank_out in NUM_RANK_OPS*RANK_WIDTH; eng_meta_out in NUM_RANK_OPS*META_WIDTH; eng_remove out NUM_RANK_OPS.
REQ-010 Downstream ports: remove in 1; valid_out out 1; rank_out out RANK_WIDTH; meta_out out META_WIDTH.
REQ-011 Statistics ports: bad_op_count out 16 (out-of-range op codes seen); drop_count out 16 (inserts refused while busy).

Function
REQ-012 Input FIFO SHALL be 2^L2_IN_DEPTH entries, first-word fall-through, holding {op, meta, flowID, weight}.
REQ-013 busy SHALL be 1 when input FIFO occupancy >= depth-1, combinationally from occupancy.
REQ-014 insert with busy=0 SHALL write one entry that cycle; insert with busy=1 SHALL discard the request and increment drop_count.
REQ-015 rank_op_in >= NUM_RANK_OPS SHALL be stored as DEFAULT_OP with metadata preserved and SHALL increment bad_op_count (only when the entry is written).
REQ-016 Both counters SHALL saturate at 16'hFFFF.
REQ-017 Dispatch: when input FIFO non-empty and eng_busy[op_head]=0, eng_insert[op_head]=1 with head fields driven on slice op_head and the FIFO popped, same cycle; all other slices insert=0, data=0.
REQ-018 Head blocked by a busy engine SHALL stall the FIFO (in-order, head-of-line blocking is intended); no bypass.
REQ-019 Collection: round-robin arbiter over eng_valid_out, gated by output FIFO occupancy < depth-1; at most one eng_remove asserted per cycle.
REQ-020 Arbiter pointer SHALL start at 0 after reset and, on each grant to engine g, move to (g+1) mod NUM_RANK_OPS; unchanged when no grant.
REQ-021 Granted engine's {rank, meta} SHALL be written to the output FIFO (2^L2_OUT_DEPTH entries, fall-through) in the grant cycle.
REQ-022 valid_out = output FIFO non-empty; rank_out/meta_out = head entry; remove with valid_out=1 pops; remove with valid_out=0 SHALL be ignored.
REQ-023 Simultaneous FIFO write and read SHALL be legal in the same cycle, including at full-threshold and at empty (occupancy unchanged).
REQ-024 Latency: empty pipe, idle engine: insert at cycle t -> eng_insert at cycle t+1; engine valid at t' -> valid_out at t'+1.

Reset
REQ-025 rst low SHALL asynchronously clear both FIFOs, arbiter pointer, and both counters.
REQ-026 During and after reset: busy=0, valid_out=0, eng_insert=0, eng_remove=0, rank_out=0, meta_out=0, counters=0.
REQ-027 Reset mid-operation SHALL discard all buffered entries; no entry is delivered after reset deasserts.

Verification
REQ-028 Insert op=1, meta=16'hA5A5, flowID=3 into idle pipe -> eng_insert[1]=1 next cycle with meta 16'hA5A5, flowID 3.
REQ-029 NUM_RANK_OPS=3, insert op=3 -> delivered to engine DEFAULT_OP=0; bad_op_count=1.
REQ-030 Hold eng_busy[0]=1, insert 16 entries op=0 (depth 16) -> busy asserts after 15; 16th refused, drop_count=1; release -> 15 dispatched in order.
REQ-031 All 4 eng_valid_out held high for 8 cycles, output never full -> grants 0,1,2,3,0,1,2,3.
REQ-032 Output FIFO at 15 entries, remove=1 and engine valid same cycle -> write and pop both occur, occupancy stays 15.
REQ-033 rst low while 5 entries buffered -> valid_out=0, busy=0 immediately; after release no outputs without new inserts.
